// File: rtl/uart_xcvr_if.sv
// Client-side bundle for the UART transceiver: TX byte handshake, RX word
// delivery and the two serial pins. The DUT takes the slave view.
interface uart_xcvr_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx;
   logic                 tx_done;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_parity_err;
   logic                 rx_frame_err;

   modport master (
      output tx_data, tx_valid, rx,
      input  tx_ready, tx, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );

   modport slave (
      input  tx_data, tx_valid, rx,
      output tx_ready, tx, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );
endinterface

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver: one free-running baud-tick enable shared by
// an independent transmitter and a 16x-oversampled receiver.
module uart_xcvr #(
   parameter int CLK_FREQ   = 1_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input logic         clk,
   input logic         rst,
   uart_xcvr_if.slave  bus
);
   localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int TCW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OCW     = $clog2(OVERSAMPLE);
   localparam int IDXW    = $clog2(DATA_BITS);

   localparam logic [TCW-1:0]  TICK_LAST = TCW'(DIV - 1);
   localparam logic [OCW-1:0]  BIT_LAST  = OCW'(OVERSAMPLE - 1);
   localparam logic [OCW-1:0]  HALF_LAST = OCW'(OVERSAMPLE / 2 - 1);
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DATA_BITS - 1);
   localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic            ODD       = (PARITY == 1);

   localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
                          TX_PAR  = 3'd3, TX_STOP  = 3'd4;
   localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
                          RX_PAR  = 3'd3, RX_STOP  = 3'd4, RX_BREAK = 3'd5;

   logic [TCW-1:0]       tick_cnt;
   logic                 tick;

   logic [2:0]           tx_state;
   logic [OCW-1:0]       tx_cnt;
   logic [IDXW-1:0]      tx_idx;
   logic                 tx_stop;
   logic [DATA_BITS-1:0] tx_shreg;
   logic                 tx_par;
   logic                 tx_line;
   logic                 tx_last;
   logic                 tx_fin;
   logic                 accept;

   logic                 sync1, sync2;
   logic                 rxs;
   logic [2:0]           rx_state;
   logic [OCW-1:0]       rx_cnt;
   logic [IDXW-1:0]      rx_idx;
   logic [DATA_BITS-1:0] rx_shreg;
   logic                 rx_perr_pend;
   logic                 rx_last;
   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rx_perr_r, rx_ferr_r, rx_valid_r;

   assign tick    = (tick_cnt == TICK_LAST);
   assign tx_last = (tx_cnt == BIT_LAST);
   assign rx_last = (rx_cnt == BIT_LAST);
   assign rxs     = sync2;

   // The last stop tick frees the transmitter in the same cycle so a waiting
   // word follows with no idle gap.
   assign tx_fin   = (tx_state == TX_STOP) && tick && tx_last && (tx_stop == STOP_LAST);
   assign accept   = bus.tx_valid && bus.tx_ready;

   assign bus.tx_ready      = (tx_state == TX_IDLE) || tx_fin;
   assign bus.tx_done       = tx_fin;
   assign bus.tx            = tx_line;
   assign bus.rx_data       = rx_data_r;
   assign bus.rx_valid      = rx_valid_r;
   assign bus.rx_parity_err = rx_perr_r;
   assign bus.rx_frame_err  = rx_ferr_r;

   // Free-running divider producing the shared oversample tick.
   always_ff @(posedge clk) begin
      if (rst)                   tick_cnt <= '0;
      else if (tick)             tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;
   end

   // Transmit FSM; tx is registered so the pin never glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_stop  <= 1'b0;
         tx_shreg <= '0;
         tx_par   <= 1'b0;
         tx_line  <= 1'b1;
      end else begin
         case (tx_state)
            TX_START: if (tick) begin
               if (tx_last) begin
                  tx_cnt   <= '0;
                  tx_idx   <= '0;
                  tx_line  <= tx_shreg[0];
                  tx_state <= TX_DATA;
               end else tx_cnt <= tx_cnt + 1'b1;
            end
            TX_DATA: if (tick) begin
               if (tx_last) begin
                  tx_cnt <= '0;
                  if (tx_idx == IDX_LAST) begin
                     tx_stop <= 1'b0;
                     if (PARITY != 0) begin
                        tx_line  <= tx_par;
                        tx_state <= TX_PAR;
                     end else begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                     end
                  end else begin
                     tx_idx   <= tx_idx + 1'b1;
                     tx_line  <= tx_shreg[1];
                     tx_shreg <= tx_shreg >> 1;
                  end
               end else tx_cnt <= tx_cnt + 1'b1;
            end
            TX_PAR: if (tick) begin
               if (tx_last) begin
                  tx_cnt   <= '0;
                  tx_line  <= 1'b1;
                  tx_state <= TX_STOP;
               end else tx_cnt <= tx_cnt + 1'b1;
            end
            TX_STOP: if (tick) begin
               if (tx_last) begin
                  tx_cnt <= '0;
                  if (tx_stop == STOP_LAST) tx_state <= TX_IDLE;
                  else                      tx_stop  <= tx_stop + 1'b1;
               end else tx_cnt <= tx_cnt + 1'b1;
            end
            default: begin
               tx_state <= TX_IDLE;
               tx_line  <= 1'b1;
            end
         endcase
         if (accept) begin
            tx_shreg <= bus.tx_data;
            tx_par   <= (^bus.tx_data) ^ ODD;
            tx_cnt   <= '0;
            tx_line  <= 1'b0;
            tx_state <= TX_START;
         end
      end
   end

   // Two-flop synchroniser for the asynchronous rx pin, idling high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= bus.rx;
         sync2 <= sync1;
      end
   end

   // Receive FSM: mid-bit sampling on ticks, results published at the stop sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_idx       <= '0;
         rx_shreg     <= '0;
         rx_perr_pend <= 1'b0;
         rx_data_r    <= '0;
         rx_perr_r    <= 1'b0;
         rx_ferr_r    <= 1'b0;
         rx_valid_r   <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         case (rx_state)
            RX_IDLE: if (tick && !rxs) begin
               rx_cnt   <= '0;
               rx_state <= RX_START;
            end
            RX_START: if (tick) begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rxs ? RX_IDLE : RX_DATA;
               end else rx_cnt <= rx_cnt + 1'b1;
            end
            RX_DATA: if (tick) begin
               if (rx_last) begin
                  rx_cnt   <= '0;
                  rx_shreg <= {rxs, rx_shreg[DATA_BITS-1:1]};
                  if (rx_idx == IDX_LAST) rx_state <= (PARITY != 0) ? RX_PAR : RX_STOP;
                  else                    rx_idx   <= rx_idx + 1'b1;
               end else rx_cnt <= rx_cnt + 1'b1;
            end
            RX_PAR: if (tick) begin
               if (rx_last) begin
                  rx_cnt       <= '0;
                  rx_perr_pend <= rxs ^ (^rx_shreg) ^ ODD;
                  rx_state     <= RX_STOP;
               end else rx_cnt <= rx_cnt + 1'b1;
            end
            RX_STOP: if (tick) begin
               if (rx_last) begin
                  rx_cnt     <= '0;
                  rx_data_r  <= rx_shreg;
                  rx_perr_r  <= (PARITY != 0) && rx_perr_pend;
                  rx_ferr_r  <= ~rxs;
                  rx_valid_r <= 1'b1;
                  rx_state   <= rxs ? RX_IDLE : RX_BREAK;
               end else rx_cnt <= rx_cnt + 1'b1;
            end
            RX_BREAK: if (tick && rxs) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule
